pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register replacing the per-stage, per-bit register banks between decode, execute, memory and writeback. It carries a data payload, a control-bit group and a destination-register index under a valid/ready handshake. An optional skid entry keeps full throughput while cutting the combinational ready path. Flush support squashes wrong-path instructions on branches.

---
 rtl/pipe_stage_reg_pkg.sv | 30 +++
 rtl/pipe_if.sv | 35 +++
 rtl/pipe_stage_reg_entry.sv | 26 ++
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-bit positions, stage state encoding
// and the state-to-occupancy mapping used by pipe_stage_reg.
package pipe_stage_reg_pkg;

    // Positions inside the control-bit group carried with each instruction
    localparam int unsigned CTRL_RD_MEM = 0;
    localparam int unsigned CTRL_WR_MEM = 1;
    localparam int unsigned CTRL_BYTE   = 2;
    localparam int unsigned CTRL_WR_REG = 3;

    // Width of the occupancy count (0..2 entries)
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Number of entries held in a given state
    function automatic logic [OCC_W-1:0] state_occupancy(input stage_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            MAIN:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_if.sv
// Valid/ready pipeline bus carrying payload, control bits and destination index.
//   valid  master->slave  word present
//   ready  slave->master  word accepted this cycle
//   data   master->slave  payload (DATA_W)
//   ctrl   master->slave  control-bit group (CTRL_W)
//   rd     master->slave  destination register index (IDX_W)
interface pipe_if #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned IDX_W  = 5
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [IDX_W-1:0]  rd;

    modport master (
        output valid,
        output data,
        output ctrl,
        output rd,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        input  rd,
        output ready
    );

endinterface

// File: rtl/pipe_stage_reg_entry.sv
// pipe_entry: one pipeline entry register with synchronous reset and load enable.
//   clk    rising-edge clock
//   reset  synchronous active-high clear
//   load   capture d on this edge
//   d      next entry value (W bits)
//   q      held entry value (W bits)
module pipe_entry #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with valid/ready handshake,
// optional skid entry and synchronous flush.
//   clk        rising-edge clock
//   reset      synchronous active-high reset, highest priority
//   flush      squash all held entries (beats any handshake)
//   in_bus     upstream slave port (valid/ready/data/ctrl/rd)
//   out_bus    downstream master port; ctrl reads 0 whenever valid is 0
//   occupancy  registered count of held entries (0..2)
// SKID=1: head + skid entry, in_ready is a flop (no out_ready path).
// SKID=0: head only, in_ready = !out_valid || out_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_if.slave            in_bus,
    pipe_if.master           out_bus,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned ENT_W    = DATA_W + CTRL_W + IDX_W;
    localparam int unsigned CTRL_LSB = IDX_W;
    localparam int unsigned DATA_LSB = IDX_W + CTRL_W;

    stage_state_e     state_q;
    stage_state_e     state_d;
    logic [ENT_W-1:0] in_word;
    logic [ENT_W-1:0] bubble_word;
    logic [ENT_W-1:0] head_q;
    logic [ENT_W-1:0] head_d;
    logic [ENT_W-1:0] skid_q;
    logic             head_load;
    logic             skid_load;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             in_ready_int;
    logic             out_valid_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_fire;
    logic             out_fire;

    assign in_word  = {in_bus.data, in_bus.ctrl, in_bus.rd};
    assign in_fire  = in_bus.valid && in_ready_int;
    assign out_fire = out_valid_q && out_bus.ready;

    // Head contents once it stops being valid: payload and index hold, ctrl clears
    assign bubble_word = {head_q[ENT_W-1:DATA_LSB], CTRL_W'(0), head_q[IDX_W-1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, entry loads and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        head_d    = in_word;
        skid_load = 1'b0;

        if (flush) begin
            state_d = EMPTY;
            if (state_q != EMPTY) begin
                head_load = 1'b1;
                head_d    = bubble_word;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = MAIN;
                        head_load = 1'b1;
                    end
                end
                MAIN: begin
                    case ({in_fire, out_fire})
                        2'b11: begin
                            head_load = 1'b1;
                        end
                        2'b10: begin
                            // Only reachable with a skid entry: SKID=0 needs out_ready to accept
                            state_d   = FULL;
                            skid_load = 1'b1;
                        end
                        2'b01: begin
                            state_d   = EMPTY;
                            head_load = 1'b1;
                            head_d    = bubble_word;
                        end
                        default: begin
                            state_d = MAIN;
                        end
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only the drain case matters
                    if (out_fire) begin
                        state_d   = MAIN;
                        head_load = 1'b1;
                        head_d    = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != FULL);
        occ_d      = state_occupancy(state_d);
    end

    // Registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occupancy   <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= (state_d != EMPTY);
            occupancy   <= occ_d;
        end
    end

    // Head entry: always the oldest word
    pipe_entry #(.W(ENT_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    // Skid entry and in_ready style
    if (SKID != 0) begin : g_skid
        pipe_entry #(.W(ENT_W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .d     (in_word),
            .q     (skid_q)
        );
        assign in_ready_int = in_ready_q;
    end else begin : g_noskid
        logic unused_skid_load;
        assign unused_skid_load = skid_load;
        assign skid_q           = '0;
        // in_ready_q only masks the reset cycles; acceptance follows the downstream
        assign in_ready_int     = in_ready_q && (!out_valid_q || out_bus.ready);
    end

    assign in_bus.ready  = in_ready_int;
    assign out_bus.valid = out_valid_q;
    assign out_bus.data  = head_q[ENT_W-1:DATA_LSB];
    assign out_bus.ctrl  = head_q[DATA_LSB-1:CTRL_LSB];
    assign out_bus.rd    = head_q[IDX_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share payload
// stimulus and are each compared every cycle against a small FIFO model.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned DATA_W = 96;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned IDX_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [IDX_W-1:0]  rd;
    } word_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [DATA_W-1:0] din;
    logic [CTRL_W-1:0] cin;
    logic [IDX_W-1:0]  rin;
    logic              iv   [2];
    logic              ordy [2];
    logic [1:0]        occ_s;
    logic [1:0]        occ_f;

    always #5 clk = ~clk;

    pipe_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) in_s  ();
    pipe_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) out_s ();
    pipe_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) in_f  ();
    pipe_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) out_f ();

    assign in_s.valid  = iv[0];
    assign in_s.data   = din;
    assign in_s.ctrl   = cin;
    assign in_s.rd     = rin;
    assign out_s.ready = ordy[0];
    assign in_f.valid  = iv[1];
    assign in_f.data   = din;
    assign in_f.ctrl   = cin;
    assign in_f.rd     = rin;
    assign out_f.ready = ordy[1];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W), .SKID(1)) dut_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_bus    (in_s),
        .out_bus   (out_s),
        .occupancy (occ_s)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W), .SKID(0)) dut_flow (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_bus    (in_f),
        .out_bus   (out_f),
        .occupancy (occ_f)
    );

    // Reference: per instance, an ordered list of held words (oldest first)
    word_t mq [2][2];
    int    cnt [2];
    int    emit_cnt [2];
    bit    rdy_en;
    logic  exp_rdy [2];
    int    checks;
    int    errors;
    int    cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare one instance's outputs against the model
    task automatic cmp_dut(input int i, input logic rdy, input logic vld,
                           input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                           input logic [IDX_W-1:0] r, input logic [1:0] occ);
        int cap;
        cap = (i == 0) ? 2 : 1;
        exp_rdy[i] = rdy_en && ((cnt[i] < cap) || (cnt[i] > 0 && ordy[i] == 1'b1 && i == 1));
        check($sformatf("c%0d u%0d in_ready", cyc, i), 128'(rdy), 128'(exp_rdy[i]));
        check($sformatf("c%0d u%0d out_valid", cyc, i), 128'(vld), 128'(cnt[i] > 0));
        check($sformatf("c%0d u%0d occupancy", cyc, i), 128'(occ), 128'(cnt[i]));
        if (cnt[i] > 0) begin
            check($sformatf("c%0d u%0d out_ctrl", cyc, i), 128'(c), 128'(mq[i][0].ctrl));
            check($sformatf("c%0d u%0d out_data", cyc, i), 128'(d), 128'(mq[i][0].data));
            check($sformatf("c%0d u%0d out_rd", cyc, i), 128'(r), 128'(mq[i][0].rd));
        end else begin
            check($sformatf("c%0d u%0d bubble ctrl", cyc, i), 128'(c), 128'(0));
        end
    endtask

    task automatic model_update();
        logic acc_in;
        logic acc_out;
        if (reset) begin
            cnt[0] = 0;
            cnt[1] = 0;
            rdy_en = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc_in  = iv[i] && exp_rdy[i];
                acc_out = (cnt[i] > 0) && ordy[i];
                if (acc_out) emit_cnt[i]++;
                if (flush) begin
                    cnt[i] = 0;
                end else begin
                    if (acc_out) begin
                        mq[i][0] = mq[i][1];
                        cnt[i]--;
                    end
                    if (acc_in) begin
                        mq[i][cnt[i]] = word_t'({din, cin, rin});
                        cnt[i]++;
                    end
                end
            end
            rdy_en = 1'b1;
        end
    endtask

    // Inputs are set at the falling edge; sample, then advance one clock
    task automatic step();
        #1;
        cmp_dut(0, in_s.ready, out_s.valid, out_s.data, out_s.ctrl, out_s.rd, occ_s);
        cmp_dut(1, in_f.ready, out_f.valid, out_f.data, out_f.ctrl, out_f.rd, occ_f);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_hs(input logic v0, input logic v1, input logic r0, input logic r1);
        iv[0]   = v0;
        iv[1]   = v1;
        ordy[0] = r0;
        ordy[1] = r1;
    endtask

    task automatic check_reset_zero(input string tag);
        #1;
        check({tag, " data0"}, 128'(out_s.data), 128'(0));
        check({tag, " rd0"}, 128'(out_s.rd), 128'(0));
        check({tag, " data1"}, 128'(out_f.data), 128'(0));
        check({tag, " rd1"}, 128'(out_f.rd), 128'(0));
    endtask

    initial begin
        int e0;
        int e1;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        cnt[0]   = 0;
        cnt[1]   = 0;
        emit_cnt[0] = 0;
        emit_cnt[1] = 0;
        rdy_en   = 1'b0;
        reset    = 1'b1;
        flush    = 1'b0;
        din      = '0;
        cin      = '0;
        rin      = '0;
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step();
        step();
        check_reset_zero("reset");
        reset = 1'b0;
        step();
        step();

        // Single push with write_reg set
        din = {64'h0, 32'hDEADBEEF};
        cin = '0;
        cin[CTRL_WR_REG] = 1'b1;
        rin = 5'd5;
        set_hs(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("push data", 128'(out_s.data), 128'(32'hDEADBEEF));
        check("push ctrl", 128'(out_s.ctrl), 128'(4'b1000));
        check("push rd", 128'(out_s.rd), 128'(5));
        check("push occ", 128'(occ_s), 128'(1));
        step();
        step();

        // Streaming 0..15
        e0 = emit_cnt[0];
        e1 = emit_cnt[1];
        for (int k = 0; k < 16; k++) begin
            din = DATA_W'(k);
            cin = CTRL_W'($urandom);
            rin = IDX_W'(k);
            set_hs(1'b1, 1'b1, 1'b1, 1'b1);
            step();
        end
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check("stream count0", 128'(emit_cnt[0] - e0), 128'(16));
        check("stream count1", 128'(emit_cnt[1] - e1), 128'(16));

        // Backpressure: A, B, then a refused C
        set_hs(1'b1, 1'b1, 1'b0, 1'b0);
        din = DATA_W'(32'hA); rin = 5'd10; cin = 4'b0001;
        step();
        din = DATA_W'(32'hB); rin = 5'd11; cin = 4'b0010;
        step();
        din = DATA_W'(32'hC); rin = 5'd12; cin = 4'b0100;
        #1;
        check("bp occ", 128'(occ_s), 128'(2));
        check("bp in_ready", 128'(in_s.ready), 128'(0));
        check("bp head", 128'(out_s.data), 128'(32'hA));
        step();
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step();

        // Flush while full with an incoming word
        set_hs(1'b1, 1'b1, 1'b0, 1'b0);
        din = DATA_W'(32'h1111); rin = 5'd1;
        step();
        din = DATA_W'(32'h2222); rin = 5'd2;
        step();
        flush = 1'b1;
        din = DATA_W'(32'hD0D0); rin = 5'd3; cin = 4'b1111;
        step();
        flush = 1'b0;
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("flush valid", 128'(out_s.valid), 128'(0));
        check("flush ctrl", 128'(out_s.ctrl), 128'(0));
        check("flush occ", 128'(occ_s), 128'(0));
        check("flush in_ready", 128'(in_s.ready), 128'(1));
        repeat (2) step();

        // Reset while full
        set_hs(1'b1, 1'b1, 1'b0, 1'b0);
        din = DATA_W'(32'h3333);
        step();
        din = DATA_W'(32'h4444);
        step();
        reset = 1'b1;
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check_reset_zero("midreset");
        check("midreset in_ready", 128'(in_s.ready), 128'(0));
        step();
        reset = 1'b0;
        step();
        #1;
        check("post reset in_ready", 128'(in_s.ready), 128'(1));
        step();

        // SKID=0: combinational in_ready follows out_ready
        set_hs(1'b0, 1'b1, 1'b1, 1'b0);
        din = DATA_W'(32'h5555); rin = 5'd7;
        step();
        set_hs(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("flow stall in_ready", 128'(in_f.ready), 128'(0));
        set_hs(1'b0, 1'b1, 1'b1, 1'b1);
        din = DATA_W'(32'h6666); rin = 5'd8;
        #1;
        check("flow release in_ready", 128'(in_f.ready), 128'(1));
        step();
        set_hs(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(199) == 0);
            flush = ($urandom_range(29) == 0);
            din   = {$urandom, $urandom, $urandom};
            cin   = CTRL_W'($urandom);
            rin   = IDX_W'($urandom);
            set_hs(1'($urandom), 1'($urandom),
                   ($urandom_range(9) < 7), ($urandom_range(9) < 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
